axi_sbus_bridge: RTL

AXI_SBUS_BRIDGE -- requirements
Module: axi_sbus_bridge

---
 rtl/axi_sbus_bridge.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/axi_sbus_bridge.sv
// AXI4 slave to single-outstanding simple-bus bridge; one bus transfer per AXI beat.
// Optional macro AXI_SBUS_ERR_EN returns bus err as SLVERR on R and (sticky) on B.
module axi_sbus_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic [7:0]        s_awlen,
    input  logic [1:0]        s_awburst,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wlast,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic [7:0]        s_arlen,
    input  logic [1:0]        s_arburst,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [3:0]        be,
    output logic [31:0]       wdata,
    input  logic              gnt,
    input  logic              rvalid,
    input  logic [31:0]       rdata,
    input  logic              err
);

    typedef enum logic [2:0] {
        IDLE, WDATA, WREQ, WACK, WRESP, RREQ, RACK, RDATA
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [1:0]        r_burst;
    logic [7:0]        r_beat;
    logic              r_we;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;
    logic [1:0]        r_bresp;
    logic              r_rlast;
    logic              w_aw_hs;
    logic              w_ar_hs;
    logic              w_last_beat;
    logic [ADDR_W-1:0] w_addr_next;
    logic              w_unused;

`ifdef AXI_SBUS_ERR_EN
    assign w_unused = s_wlast;
`else
    assign w_unused = ^{s_wlast, err};
`endif

    assign w_last_beat = (r_beat == r_len);
    // FIXED holds the address; INCR, WRAP and the reserved encoding all step by one word
    assign w_addr_next = (r_burst == 2'b00) ? r_addr : r_addr + ADDR_W'(4);

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_aw_hs   = 1'b0;
        w_ar_hs   = 1'b0;
        s_awready = 1'b0;
        s_arready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_rvalid  = 1'b0;
        req       = 1'b0;
        case (r_state)
            IDLE: begin
                if (s_awvalid) begin
                    s_awready = resetn;
                    w_aw_hs   = 1'b1;
                    w_next    = WDATA;
                end else if (s_arvalid) begin
                    s_arready = resetn;
                    w_ar_hs   = 1'b1;
                    w_next    = RREQ;
                end
            end
            WDATA: begin
                s_wready = 1'b1;
                if (s_wvalid) w_next = WREQ;
            end
            WREQ: begin
                req = 1'b1;
                if (gnt) w_next = WACK;
            end
            WACK:  if (rvalid) w_next = w_last_beat ? WRESP : WDATA;
            WRESP: begin
                s_bvalid = 1'b1;
                if (s_bready) w_next = IDLE;
            end
            RREQ: begin
                req = 1'b1;
                if (gnt) w_next = RACK;
            end
            RACK:  if (rvalid) w_next = RDATA;
            RDATA: begin
                s_rvalid = 1'b1;
                if (s_rready) w_next = r_rlast ? IDLE : RREQ;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_beat  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_rresp <= '0;
            r_bresp <= '0;
            r_rlast <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_addr  <= s_awaddr;
                r_len   <= s_awlen;
                r_burst <= s_awburst;
                r_beat  <= '0;
                r_we    <= 1'b1;
                r_bresp <= 2'b00;
            end
            if (w_ar_hs) begin
                r_addr  <= s_araddr;
                r_len   <= s_arlen;
                r_burst <= s_arburst;
                r_beat  <= '0;
                r_we    <= 1'b0;
                r_be    <= 4'hF;
            end
            if (r_state == WDATA && s_wvalid) begin
                r_wdata <= s_wdata;
                r_be    <= s_wstrb;
            end
            if (r_state == WACK && rvalid) begin
                if (!w_last_beat) begin
                    r_beat <= r_beat + 8'd1;
                    r_addr <= w_addr_next;
                end
`ifdef AXI_SBUS_ERR_EN
                if (err) r_bresp <= 2'b10;
`endif
            end
            if (r_state == RACK && rvalid) begin
                r_rdata <= rdata;
                r_rlast <= w_last_beat;
`ifdef AXI_SBUS_ERR_EN
                r_rresp <= err ? 2'b10 : 2'b00;
`endif
            end
            if (r_state == RDATA && s_rready) begin
                if (r_rlast) begin
                    r_rlast <= 1'b0;
                end else begin
                    r_beat <= r_beat + 8'd1;
                    r_addr <= w_addr_next;
                end
            end
        end
    end

    assign addr    = r_addr;
    assign we      = r_we;
    assign be      = r_be;
    assign wdata   = r_wdata;
    assign s_rdata = r_rdata;
    assign s_rresp = r_rresp;
    assign s_rlast = r_rlast;
    assign s_bresp = r_bresp;

endmodule
